// File: rtl/svd_job_sched_pkg.sv
// Shared definitions for the SVD job scheduler: default widths, FSM
// state encoding and the two-way round-robin pick function.
package svd_job_sched_pkg;

   localparam int SVD_AW = 10;
   localparam int SVD_RW = 12;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   // last = index granted most recently; on a tie the other requester wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
      logic [1:0] g;
      g = 2'b00;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/svd_job_sched_if.sv
// Bus bundle between the job sources, the shared CORDIC SVD core, the result
// consumer and the scheduler.
interface svd_job_sched_if #(
   parameter int AW = svd_job_sched_pkg::SVD_AW,
   parameter int RW = svd_job_sched_pkg::SVD_RW
);
   // Handshakes: a requester holds req_valid[i] and its operands stable until
   // the cycle req_grant[i] is high; that edge consumes the job. res_valid
   // stays high with res_* stable until the cycle res_ack is high.
   logic [1:0]      req_valid;
   logic [4*AW-1:0] req_a0;
   logic [4*AW-1:0] req_a1;
   logic [1:0]      req_grant;
   logic            core_start;
   logic            core_ready;
   logic [4*AW-1:0] core_a;
   logic [4*RW-1:0] core_b;
   logic [4*RW-1:0] core_u;
   logic [4*RW-1:0] core_v;
   logic            res_valid;
   logic            res_id;
   logic            res_err;
   logic [4*RW-1:0] res_b;
   logic [4*RW-1:0] res_u;
   logic [4*RW-1:0] res_v;
   logic            res_ack;

   modport slave (
      input  req_valid, req_a0, req_a1, core_ready, core_b, core_u, core_v, res_ack,
      output req_grant, core_start, core_a, res_valid, res_id, res_err, res_b, res_u, res_v
   );

   modport master (
      output req_valid, req_a0, req_a1, core_ready, core_b, core_u, core_v, res_ack,
      input  req_grant, core_start, core_a, res_valid, res_id, res_err, res_b, res_u, res_v
   );

endinterface

// File: rtl/svd_job_sched_rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational and the
// last-grant register advances only when something is actually granted.
module svd_job_sched_rr_arb2
   import svd_job_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic last;

   assign gnt = en ? rr_pick(req, last) : 2'b00;

   // Resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/svd_job_sched.sv
// Shares one CORDIC 2x2 SVD core between two requesters: arbitration, operand
// capture, start pulse, done/timeout detection and a held result with ack.
module svd_job_sched
   import svd_job_sched_pkg::*;
#(
   parameter int AW      = SVD_AW,
   parameter int RW      = SVD_RW,
   parameter int TIMEOUT = 4096
) (
   input  logic  clk,
   input  logic  rst,
   svd_job_sched_if.slave bus,
   output state_t dbg_state
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      gnt;
   logic [TW-1:0]   timer;
   logic            waiting;
   logic            done;
   logic            timeout_hit;
   logic [4*AW-1:0] core_a_q;
   logic            res_id_q;
   logic            res_err_q;
   logic [4*RW-1:0] res_b_q;
   logic [4*RW-1:0] res_u_q;
   logic [4*RW-1:0] res_v_q;

   svd_job_sched_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.req_valid),
      .en  (state == S_IDLE),
      .gnt (gnt)
   );

   // A stale high core_ready in WAIT_LO is ignored; only WAIT_HI can see done.
   assign waiting     = (state == S_WAIT_LO) || (state == S_WAIT_HI);
   assign done        = (state == S_WAIT_HI) && bus.core_ready;
   assign timeout_hit = waiting && (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (|gnt) state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_WAIT_LO;
         S_WAIT_LO: begin
            if (timeout_hit)          state_nxt = S_HOLD;
            else if (!bus.core_ready) state_nxt = S_WAIT_HI;
         end
         S_WAIT_HI: if (done || timeout_hit) state_nxt = S_HOLD;
         S_HOLD:    if (bus.res_ack) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_a_q  <= '0;
         res_id_q  <= 1'b0;
         res_err_q <= 1'b0;
         res_b_q   <= '0;
         res_u_q   <= '0;
         res_v_q   <= '0;
         timer     <= '0;
      end else begin
         if (|gnt) begin
            core_a_q <= gnt[1] ? bus.req_a1 : bus.req_a0;
            res_id_q <= gnt[1];
         end
         if (state == S_ISSUE) begin
            timer <= '0;
         end else if (waiting) begin
            timer <= timer + TW'(1);
         end
         // Done takes priority over a timeout landing on the same cycle.
         if (done) begin
            res_b_q   <= bus.core_b;
            res_u_q   <= bus.core_u;
            res_v_q   <= bus.core_v;
            res_err_q <= 1'b0;
         end else if (timeout_hit) begin
            res_b_q   <= '0;
            res_u_q   <= '0;
            res_v_q   <= '0;
            res_err_q <= 1'b1;
         end
      end
   end

   assign bus.req_grant  = gnt;
   assign bus.core_start = (state == S_ISSUE);
   assign bus.core_a     = core_a_q;
   assign bus.res_valid  = (state == S_HOLD);
   assign bus.res_id     = res_id_q;
   assign bus.res_err    = res_err_q;
   assign bus.res_b      = res_b_q;
   assign bus.res_u      = res_u_q;
   assign bus.res_v      = res_v_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_svd_job_sched.sv
// Directed bench for svd_job_sched: behavioural core model, expected-result
// queue filled when jobs are driven, checked when results are held.
module tb_svd_job_sched;
   import svd_job_sched_pkg::*;

   localparam int TO = 16;
   localparam int AW = 10;
   localparam int RW = 12;
   localparam int EW = 2 + 12 * RW;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   state_t dbg_state;

   svd_job_sched_if #(.AW(AW), .RW(RW)) bus ();

   svd_job_sched #(.AW(AW), .RW(RW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int            checks   = 0;
   int            failures = 0;
   logic [EW-1:0] exp_q[$];

   // Core model: ready stays stale-high two cycles after start, then low
   // until core_lat cycles have passed (never rises while core_hang is set).
   int   core_lat  = 5;
   logic core_hang = 1'b0;
   int   core_cnt  = 0;
   logic core_busy = 1'b0;

   function automatic logic [4*RW-1:0] core_fn(input logic [4*AW-1:0] a, input int k);
      logic [4*RW-1:0] r;
      logic [AW-1:0]   w;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         w = a[i*AW +: AW];
         r[i*RW +: RW] = {{(RW-AW){w[AW-1]}}, w} + RW'(k * 37 + i + 1);
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.core_ready <= 1'b1;
         bus.core_b     <= '0;
         bus.core_u     <= '0;
         bus.core_v     <= '0;
         core_busy      <= 1'b0;
         core_cnt       <= 0;
      end else if (bus.core_start) begin
         core_busy <= 1'b1;
         core_cnt  <= 0;
      end else if (core_busy) begin
         core_cnt <= core_cnt + 1;
         if (core_cnt == 1) bus.core_ready <= 1'b0;
         if (core_cnt == core_lat && !core_hang) begin
            bus.core_ready <= 1'b1;
            core_busy      <= 1'b0;
            bus.core_b     <= core_fn(bus.core_a, 0);
            bus.core_u     <= core_fn(bus.core_a, 1);
            bus.core_v     <= core_fn(bus.core_a, 2);
         end
      end
   end

   int         cyc          = 0;
   int         n_grant      = 0;
   int         n_start      = 0;
   int         n_res        = 0;
   int         start_cyc    = 0;
   int         rdy_rise_cyc = 0;
   int         res_rise_cyc = 0;
   logic [1:0] last_gnt     = 2'b00;
   logic       rdy_d        = 1'b0;
   logic       res_d        = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rdy_d <= bus.core_ready;
      res_d <= bus.res_valid;
      if (bus.req_grant != 2'b00) begin
         n_grant  <= n_grant + 1;
         last_gnt <= bus.req_grant;
      end
      if (bus.core_start) begin
         n_start   <= n_start + 1;
         start_cyc <= cyc;
      end
      if (bus.core_ready === 1'b1 && rdy_d === 1'b0) rdy_rise_cyc <= cyc;
      if (bus.res_valid === 1'b1 && res_d === 1'b0) begin
         n_res        <= n_res + 1;
         res_rise_cyc <= cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic err, input logic [4*AW-1:0] ops);
      if (err) exp_q.push_back({id, err, {(12*RW){1'b0}}});
      else     exp_q.push_back({id, err, core_fn(ops, 0), core_fn(ops, 1), core_fn(ops, 2)});
   endtask

   // Returns in the cycle after the grant, i.e. the core_start cycle.
   task automatic grant_job(input string tag, input logic [1:0] exp_g, input logic [4*AW-1:0] ops);
      int n0;
      n0 = n_grant;
      for (int i = 0; i < 100 && n_grant == n0; i++) step();
      chk({tag, "_grant_seen"}, 64'(n_grant != n0), 64'd1);
      chk({tag, "_grant"}, 64'(last_gnt), 64'(exp_g));
      chk({tag, "_core_start"}, 64'(bus.core_start), 64'd1);
      chk({tag, "_core_a"}, 64'(bus.core_a), 64'(ops));
   endtask

   task automatic collect(input string tag);
      logic [EW-1:0] e;
      for (int i = 0; i < 300 && bus.res_valid !== 1'b1; i++) step();
      chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
      chk({tag, "_exp_pending"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_res_id"},  64'(bus.res_id),  64'(e[EW-1]));
         chk({tag, "_res_err"}, 64'(bus.res_err), 64'(e[EW-2]));
         chk({tag, "_res_b"},   64'(bus.res_b),   64'(e[8*RW +: 4*RW]));
         chk({tag, "_res_u"},   64'(bus.res_u),   64'(e[4*RW +: 4*RW]));
         chk({tag, "_res_v"},   64'(bus.res_v),   64'(e[0 +: 4*RW]));
      end
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      chk({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4*AW-1:0] ops_a, ops_b, ops_c, ops_d, ops_e, ops_f, ops_g, ops_s;
      logic [EW-1:0]   pk;
      int              s0, g0, r0;

      ops_s = {10'(-16), 10'(12), 10'(8), 10'(-4)};
      ops_a = {10'(100), 10'(-200), 10'(300), 10'(-511)};
      ops_b = {10'(-1), 10'(1), 10'(511), 10'(-512)};
      ops_c = {10'(7), 10'(-7), 10'(70), 10'(-70)};
      ops_d = {10'(33), 10'(44), 10'(-55), 10'(66)};
      ops_e = {10'(-123), 10'(234), 10'(-345), 10'(456)};
      ops_f = {10'(5), 10'(6), 10'(7), 10'(8)};
      ops_g = {10'(-9), 10'(19), 10'(-29), 10'(39)};

      bus.req_valid = 2'b00;
      bus.req_a0    = '0;
      bus.req_a1    = '0;
      bus.res_ack   = 1'b0;

      // Reset held: everything idle and zero.
      step();
      chk("rst_state",      64'(dbg_state),      64'(S_IDLE));
      chk("rst_req_grant",  64'(bus.req_grant),  64'd0);
      chk("rst_core_start", 64'(bus.core_start), 64'd0);
      chk("rst_core_a",     64'(bus.core_a),     64'd0);
      chk("rst_res_valid",  64'(bus.res_valid),  64'd0);
      chk("rst_res_id",     64'(bus.res_id),     64'd0);
      chk("rst_res_err",    64'(bus.res_err),    64'd0);
      chk("rst_res_b",      64'(bus.res_b),      64'd0);
      rst = 1'b1;
      repeat (5) step();
      chk("idle_no_grant", 64'(n_grant), 64'd0);
      chk("idle_no_start", 64'(n_start), 64'd0);

      // Single job from requester 0 with stale-high ready on the core.
      core_lat = 5;
      s0 = n_start;
      bus.req_a0 = ops_s;
      bus.req_valid = 2'b01;
      push_exp(1'b0, 1'b0, ops_s);
      grant_job("single0", 2'b01, ops_s);
      bus.req_valid = 2'b00;
      collect("single0");
      chk("single0_one_start", 64'(n_start - s0), 64'd1);
      chk("single0_res_latency", 64'(res_rise_cyc - rdy_rise_cyc), 64'd1);

      // Single job from requester 1.
      bus.req_a1 = ops_b;
      bus.req_valid = 2'b10;
      push_exp(1'b1, 1'b0, ops_b);
      grant_job("single1", 2'b10, ops_b);
      bus.req_valid = 2'b00;
      collect("single1");

      // Contention: both held valid for three jobs -> grants 0, 1, 0.
      bus.req_a0 = ops_a;
      bus.req_a1 = ops_b;
      bus.req_valid = 2'b11;
      push_exp(1'b0, 1'b0, ops_a);
      push_exp(1'b1, 1'b0, ops_b);
      push_exp(1'b0, 1'b0, ops_a);
      grant_job("cont0", 2'b01, ops_a);
      collect("cont0");
      grant_job("cont1", 2'b10, ops_b);
      collect("cont1");
      grant_job("cont2", 2'b01, ops_a);
      bus.req_valid = 2'b00;
      collect("cont2");

      // Timeout: the start cycle, then TO waiting cycles, then the held error.
      core_hang = 1'b1;
      bus.req_a1 = ops_c;
      bus.req_valid = 2'b10;
      push_exp(1'b1, 1'b1, ops_c);
      grant_job("tmo", 2'b10, ops_c);
      bus.req_valid = 2'b00;
      collect("tmo");
      chk("tmo_latency", 64'(res_rise_cyc - start_cyc), 64'(TO + 1));
      core_hang = 1'b0;

      // Backpressure: result held 20 cycles while another request waits.
      core_lat = 4;
      bus.req_a0 = ops_d;
      bus.req_valid = 2'b01;
      push_exp(1'b0, 1'b0, ops_d);
      grant_job("bp", 2'b01, ops_d);
      bus.req_a0 = ops_e;
      push_exp(1'b0, 1'b0, ops_e);
      for (int i = 0; i < 100 && bus.res_valid !== 1'b1; i++) step();
      g0 = n_grant;
      s0 = n_start;
      pk = exp_q[0];
      for (int i = 0; i < 20; i++) begin
         chk("bp_hold_valid", 64'(bus.res_valid), 64'd1);
         chk("bp_hold_b", 64'(bus.res_b), 64'(pk[8*RW +: 4*RW]));
         step();
      end
      chk("bp_no_grant", 64'(n_grant - g0), 64'd0);
      chk("bp_no_start", 64'(n_start - s0), 64'd0);
      collect("bp");
      grant_job("bp_next", 2'b01, ops_e);
      bus.req_valid = 2'b00;
      collect("bp_next");

      // Reset while waiting for the core to finish.
      core_lat = 12;
      bus.req_a1 = ops_f;
      bus.req_valid = 2'b10;
      grant_job("midrst", 2'b10, ops_f);
      bus.req_valid = 2'b00;
      for (int i = 0; i < 50 && dbg_state != S_WAIT_HI; i++) step();
      chk("midrst_reached_wait_hi", 64'(dbg_state), 64'(S_WAIT_HI));
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_state",      64'(dbg_state),      64'(S_IDLE));
      chk("midrst_res_valid",  64'(bus.res_valid),  64'd0);
      chk("midrst_core_start", 64'(bus.core_start), 64'd0);
      chk("midrst_core_a",     64'(bus.core_a),     64'd0);
      step();
      rst = 1'b1;
      r0 = n_res;
      repeat (20) step();
      chk("midrst_no_result", 64'(n_res - r0), 64'd0);

      // After reset the pointer is back to 1: requester 0 wins the tie.
      core_lat = 5;
      bus.req_a0 = ops_g;
      bus.req_a1 = ops_f;
      bus.req_valid = 2'b11;
      push_exp(1'b0, 1'b0, ops_g);
      grant_job("post_rst", 2'b01, ops_g);
      bus.req_valid = 2'b00;
      collect("post_rst");
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
